mc_control_fsm: RTL

Multicycle control state machine for the MultiCycleV1 RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the PC logic enable/branch controls, the instruction-register load, the register-file write and the memory bus request. It sits between the instruction register/ALU flags and the PC logic, register file and bus interface.

---
 rtl/rv32_ctrl_pkg.sv | 50 +++++
 rtl/branch_cond_eval.sv | 38 +++
 rtl/mc_control_fsm.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32_ctrl_pkg
// Shared control definitions for the MultiCycleV1 RV32I core and later cores:
//   - multicycle FSM state encodings (as reported on o_State)
//   - RV32I major opcode constants (instruction[6:0])
//   - conditional-branch funct3 constants (instruction[14:12])
//   - small opcode classification helper
// -----------------------------------------------------------------------------
package rv32_ctrl_pkg;

    // FSM state encodings; kept as plain constants so the debug port value
    // matches what existing trace tooling expects.
    localparam logic [2:0] ST_STALL  = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Conditional branch funct3 encodings (010/011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Instructions whose result is produced by the ALU/PC path and written
    // back directly without a memory access.
    function automatic logic is_direct_wb(input logic [6:0] opc);
        return (opc == OPC_OP)  || (opc == OPC_OP_IMM) ||
               (opc == OPC_LUI) || (opc == OPC_AUIPC)  ||
               (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Combinational RV32I conditional-branch resolution from funct3 and the ALU
// comparison flags.
// Ports:
//   i_Funct3   in  3  instruction[14:12]
//   i_Eq       in  1  RS1 == RS2
//   i_Lt       in  1  signed RS1 < RS2
//   i_Ltu      in  1  unsigned RS1 < RS2
//   o_Take     out 1  branch condition true (0 for reserved funct3)
//   o_Illegal  out 1  funct3 is a reserved branch encoding
// -----------------------------------------------------------------------------
module branch_cond_eval
    import rv32_ctrl_pkg::*;
(
    input  logic [2:0] i_Funct3,
    input  logic       i_Eq,
    input  logic       i_Lt,
    input  logic       i_Ltu,
    output logic       o_Take,
    output logic       o_Illegal
);

    always_comb begin
        o_Take    = 1'b0;
        o_Illegal = 1'b0;
        case (i_Funct3)
            F3_BEQ:  o_Take = i_Eq;
            F3_BNE:  o_Take = ~i_Eq;
            F3_BLT:  o_Take = i_Lt;
            F3_BGE:  o_Take = ~i_Lt;
            F3_BLTU: o_Take = i_Ltu;
            F3_BGEU: o_Take = ~i_Ltu;
            default: o_Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle control FSM for the MultiCycleV1 RV32I core. Sequences each
// instruction through FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the
// PC logic, instruction register load, register-file write and bus request.
//
// Parameters:
//   RESET_STALL  idle cycles after reset before the first fetch (0..15)
//
// Configuration macro:
//   MCCTRL_ILLEGAL_TRAP_EN  defined   : illegal opcode / branch funct3 in EXEC
//                                       enters HALT, o_Illegal sticky until reset
//                           undefined : illegal encodings retire as NOPs,
//                                       o_Illegal tied 0
//
// Ports:
//   i_Clk, i_Rst            clock, synchronous active-high reset
//   i_Opcode, i_Funct3      fields from the instruction register
//   i_Eq, i_Lt, i_Ltu       ALU comparison flags
//   i_MemAck                bus completion (may arrive in the request cycle)
//   o_MemReq, o_MemWe       bus request and write qualifier
//   o_MemIsFetch            1 = PC address, 0 = ALU data address
//   o_IREn                  instruction register load
//   o_RegWrEn               register-file write strobe
//   o_PCEn                  PC update, one pulse per retired instruction
//   o_TakeBranch            PC branch select
//   o_BranchSrc             0 = PC+Imm, 1 = RS1+Imm
//   o_Illegal               illegal-instruction halt flag
//   o_State                 current state (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int RESET_STALL = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [6:0] i_Opcode,
    input  logic [2:0] i_Funct3,
    input  logic       i_Eq,
    input  logic       i_Lt,
    input  logic       i_Ltu,
    input  logic       i_MemAck,
    output logic       o_MemReq,
    output logic       o_MemWe,
    output logic       o_MemIsFetch,
    output logic       o_IREn,
    output logic       o_RegWrEn,
    output logic       o_PCEn,
    output logic       o_TakeBranch,
    output logic       o_BranchSrc,
    output logic       o_Illegal,
    output logic [2:0] o_State
);

    logic [2:0] r_State;
    logic [2:0] w_NextState;
    logic [3:0] r_StallCnt;
    // Captured in EXEC so WB/MEM do not depend on the opcode staying stable
    logic       r_IsJump;
    logic       r_JumpSrc;
    logic       r_IsStore;

    logic       w_BrTake;
    logic       w_BrIllegal;
    logic       w_ExecIllegal;

    branch_cond_eval u_branch_cond_eval (
        .i_Funct3  (i_Funct3),
        .i_Eq      (i_Eq),
        .i_Lt      (i_Lt),
        .i_Ltu     (i_Ltu),
        .o_Take    (w_BrTake),
        .o_Illegal (w_BrIllegal)
    );

    always_comb begin
        w_NextState   = r_State;
        w_ExecIllegal = 1'b0;
        o_MemReq      = 1'b0;
        o_MemWe       = 1'b0;
        o_MemIsFetch  = 1'b0;
        o_IREn        = 1'b0;
        o_RegWrEn     = 1'b0;
        o_PCEn        = 1'b0;
        o_TakeBranch  = 1'b0;
        o_BranchSrc   = 1'b0;

        case (r_State)
            ST_STALL: begin
                if (r_StallCnt == 4'd0) begin
                    w_NextState = ST_FETCH;
                end
            end

            ST_FETCH: begin
                o_MemReq     = 1'b1;
                o_MemIsFetch = 1'b1;
                // IR captures the bus data on the same edge the ack is seen
                if (i_MemAck) begin
                    o_IREn      = 1'b1;
                    w_NextState = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_NextState = ST_EXEC;
            end

            ST_EXEC: begin
                if (is_direct_wb(i_Opcode)) begin
                    w_NextState = ST_WB;
                end else begin
                    case (i_Opcode)
                        OPC_LOAD, OPC_STORE: begin
                            w_NextState = ST_MEM;
                        end
                        OPC_BRANCH: begin
                            if (w_BrIllegal) begin
                                w_ExecIllegal = 1'b1;
                            end else begin
                                o_PCEn       = 1'b1;
                                o_TakeBranch = w_BrTake;
                                w_NextState  = ST_FETCH;
                            end
                        end
                        OPC_MISC_MEM, OPC_SYSTEM: begin
                            o_PCEn      = 1'b1;
                            w_NextState = ST_FETCH;
                        end
                        default: begin
                            w_ExecIllegal = 1'b1;
                        end
                    endcase
                end

                if (w_ExecIllegal) begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    w_NextState = ST_HALT;
`else
                    // Retire as a NOP: sequential PC, no writeback
                    o_PCEn      = 1'b1;
                    w_NextState = ST_FETCH;
`endif
                end
            end

            ST_MEM: begin
                o_MemReq = 1'b1;
                o_MemWe  = r_IsStore;
                if (i_MemAck) begin
                    if (r_IsStore) begin
                        o_PCEn      = 1'b1;
                        w_NextState = ST_FETCH;
                    end else begin
                        w_NextState = ST_WB;
                    end
                end
            end

            ST_WB: begin
                o_RegWrEn    = 1'b1;
                o_PCEn       = 1'b1;
                o_TakeBranch = r_IsJump;
                o_BranchSrc  = r_IsJump & r_JumpSrc;
                w_NextState  = ST_FETCH;
            end

            ST_HALT: begin
                w_NextState = ST_HALT;
            end

            default: begin
                w_NextState = ST_STALL;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= ST_STALL;
            r_StallCnt <= 4'(RESET_STALL);
            r_IsJump   <= 1'b0;
            r_JumpSrc  <= 1'b0;
            r_IsStore  <= 1'b0;
        end else begin
            r_State <= w_NextState;
            if ((r_State == ST_STALL) && (r_StallCnt != 4'd0)) begin
                r_StallCnt <= r_StallCnt - 4'd1;
            end
            if (r_State == ST_EXEC) begin
                r_IsJump  <= (i_Opcode == OPC_JAL) || (i_Opcode == OPC_JALR);
                r_JumpSrc <= (i_Opcode == OPC_JALR);
                r_IsStore <= (i_Opcode == OPC_STORE);
            end
        end
    end

`ifdef MCCTRL_ILLEGAL_TRAP_EN
    // HALT is only left through reset, so the state itself is the sticky flag
    assign o_Illegal = (r_State == ST_HALT);
`else
    assign o_Illegal = 1'b0;
`endif

    assign o_State = r_State;

endmodule
